// File: rtl/uart_rcvr.sv
// uart_rcvr: oversampled UART receiver with ready/acknowledge handshake and overrun/framing flags
module uart_rcvr #(
    parameter int word_size   = 8,
    parameter int sample_rate = 8
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic                 Serial_in,
    input  logic                 read_done,
    output logic [word_size-1:0] RCV_datareg,
    output logic                 read_not_ready_out,
    output logic                 Error1,
    output logic                 Error2
);
    localparam int half_count = sample_rate / 2;
    localparam int SW = $clog2(sample_rate);
    localparam int BW = $clog2(word_size + 1) + 1;
    localparam logic [1:0] IDLE = 2'd0, STARTING = 2'd1, RECEIVING = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [word_size-1:0] shift_q, shift_d, data_q, data_d;
    logic                 rdy_q, rdy_d, err1_q, err1_d, err2_q, err2_d;
    logic                 sample, done;

    always_comb begin
        sample  = state_q == RECEIVING && samp_q == SW'(sample_rate - 1);
        done    = sample && bit_q == BW'(word_size);
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = done ? shift_q : data_q;
        rdy_d   = done ? 1'b1 : (read_done ? 1'b0 : rdy_q);
        err1_d  = done ? (rdy_q && !read_done) : err1_q;
        err2_d  = done ? !Serial_in : err2_q;
        case (state_q)
            IDLE: begin
                samp_d = '0;
                bit_d  = '0;
                if (!Serial_in) begin
                    state_d = STARTING;
                    samp_d  = SW'(1);
                end
            end
            STARTING: begin
                if (Serial_in) begin
                    state_d = IDLE;
                    samp_d  = '0;
                end else if (samp_q == SW'(half_count - 1)) begin
                    state_d = RECEIVING;
                    samp_d  = '0;
                    bit_d   = '0;
                end else begin
                    samp_d = samp_q + 1'b1;
                end
            end
            RECEIVING: begin
                // bit counter past the stop bit means the frame finished on the previous edge
                if (bit_q > BW'(word_size)) begin
                    state_d = IDLE;
                    samp_d  = '0;
                    bit_d   = '0;
                end else begin
                    samp_d = sample ? '0 : samp_q + 1'b1;
                    if (sample) begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q < BW'(word_size))
                            shift_d = {Serial_in, shift_q[word_size-1:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst_b) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            err1_q  <= 1'b0;
            err2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            err1_q  <= err1_d;
            err2_q  <= err2_d;
        end
    end

    assign RCV_datareg        = data_q;
    assign read_not_ready_out = rdy_q;
    assign Error1             = err1_q;
    assign Error2             = err2_q;
endmodule

// File: tb/tb_uart_rcvr.sv
// tb_uart_rcvr: directed frames at 8 samples/bit, checked against hand-computed outputs
module tb_uart_rcvr;
    logic       Clock, rst_b, Serial_in, read_done;
    logic [7:0] RCV_datareg;
    logic       read_not_ready_out, Error1, Error2;
    int         total = 0;
    int         passed = 0;

    uart_rcvr #(.word_size(8), .sample_rate(8)) dut (
        .Clock(Clock),
        .rst_b(rst_b),
        .Serial_in(Serial_in),
        .read_done(read_done),
        .RCV_datareg(RCV_datareg),
        .read_not_ready_out(read_not_ready_out),
        .Error1(Error1),
        .Error2(Error2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic r, input logic e1, input logic e2);
        chk({tag, ".data"}, RCV_datareg, d);
        chk({tag, ".ready"}, {7'd0, read_not_ready_out}, {7'd0, r});
        chk({tag, ".err1"}, {7'd0, Error1}, {7'd0, e1});
        chk({tag, ".err2"}, {7'd0, Error2}, {7'd0, e2});
    endtask

    // line level in cycle c of a frame: slot 0 start, slots 1..8 data LSB-first, slot 9 stop; high from cycle 77 on
    function automatic logic bit_at(input logic [7:0] d, input logic stp, input int c);
        int s;
        s = c / 8;
        if (c >= 77) return 1'b1;
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        return stp;
    endfunction

    task automatic run(input logic [7:0] d, input logic stp, input logic rd, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            Serial_in = bit_at(d, stp, c);
            read_done = rd && c == 75;
            tick();
        end
        read_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] d, input logic stp, input logic rd);
        run(d, stp, rd, 0, 79);
    endtask

    task automatic idle(input int n);
        Serial_in = 1'b1;
        read_done = 1'b0;
        repeat (n) tick();
    endtask

    task automatic ack();
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        Serial_in = 1'b0;
        read_done = 1'b0;
        repeat (3) tick();
        chk_all("reset", 8'h00, 0, 0, 0);
        rst_b = 1'b0;
        idle(4);
        chk_all("post_reset", 8'h00, 0, 0, 0);

        run(8'hA5, 1, 0, 0, 74);
        chk("a5_before_stop.ready", {7'd0, read_not_ready_out}, 8'd0);
        run(8'hA5, 1, 0, 75, 79);
        chk_all("a5", 8'hA5, 1, 0, 0);
        ack();
        chk_all("a5_ack", 8'hA5, 0, 0, 0);

        Serial_in = 1'b0;
        repeat (2) tick();
        idle(6);
        chk_all("glitch2", 8'hA5, 0, 0, 0);
        Serial_in = 1'b0;
        repeat (3) tick();
        idle(6);
        chk_all("glitch3", 8'hA5, 0, 0, 0);
        frame(8'h3C, 1, 0);
        chk_all("3c", 8'h3C, 1, 0, 0);
        ack();

        frame(8'h5A, 0, 0);
        chk_all("framing", 8'h5A, 1, 0, 1);
        ack();
        chk_all("framing_ack", 8'h5A, 0, 0, 1);
        frame(8'h01, 1, 0);
        chk_all("01", 8'h01, 1, 0, 0);
        ack();

        frame(8'h11, 1, 0);
        chk_all("11", 8'h11, 1, 0, 0);
        frame(8'h22, 1, 0);
        chk_all("overrun", 8'h22, 1, 1, 0);
        ack();
        chk_all("overrun_ack", 8'h22, 0, 1, 0);
        frame(8'h11, 1, 0);
        chk_all("11b", 8'h11, 1, 0, 0);
        frame(8'h22, 1, 1);
        chk_all("ack_at_done", 8'h22, 1, 0, 0);

        // reset at cycle 40 of an all-zero frame; the low tail then looks like a new start at cycle 41
        run(8'h00, 1, 0, 0, 39);
        rst_b = 1'b1;
        Serial_in = bit_at(8'h00, 1, 40);
        tick();
        rst_b = 1'b0;
        chk_all("mid_reset", 8'h00, 0, 0, 0);
        run(8'h00, 1, 0, 41, 79);
        idle(45);
        chk_all("tail_frame", 8'hF8, 1, 0, 0);
        ack();
        frame(8'hFF, 1, 0);
        chk_all("ff", 8'hFF, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rcvr.md
Name: uart_rcvr

Overview:
Serial receiver paired with the UART transmitter; it consumes the transmitter's serial output. The line is oversampled on Clock at sample_rate samples per bit. Each frame has one start bit, word_size data bits LSB-first, and one stop bit. The block detects and validates the start bit, samples each bit at mid-bit, and presents the assembled byte in a holding register. A ready/acknowledge handshake and overrun/framing error flags go to the host.

Parameters:
word_size, 8, number of data bits per frame
sample_rate, 8, Clock cycles per serial bit; power of two, >= 4
Derived locally: half_count = sample_rate/2; sample counter width = log2(sample_rate); bit counter width = log2(word_size+1)+1

Ports:
Clock  input  1  oversampling clock, rising-edge; all state updates here
rst_b  input  1  synchronous reset, active-high (asserted = 1), sampled on rising Clock
Serial_in  input  1  serial line; idle high; no internal synchronizer
read_done  input  1  host acknowledge pulse; clears read_not_ready_out
RCV_datareg  output  word_size  last received data word, LSB = first data bit on line
read_not_ready_out  output  1  1 = unread word valid in RCV_datareg
Error1  output  1  overrun: frame completed while previous word still unread
Error2  output  1  framing: stop bit sampled as 0

Behaviour:
- Reset: when rst_b = 1 at a Clock edge, the block returns to IDLE and clears all counters and the shift register. RCV_datareg = 0, read_not_ready_out = 0, Error1 = 0, Error2 = 0. Reset mid-frame abandons the frame without updating any output.
- State machine (registered state): IDLE, STARTING, RECEIVING.
- IDLE: sample counter = 0, bit counter = 0. Serial_in = 0 moves the block to STARTING with sample counter = 1. Otherwise it stays in IDLE.
- STARTING:
  - Serial_in = 1 → IDLE (glitch rejected, no output change).
  - Serial_in = 0 with sample counter = half_count-1 → start bit confirmed; go to RECEIVING with sample counter = 0 and bit counter = 0.
  - Otherwise, increment the sample counter.
- RECEIVING: the sample counter increments every cycle. When it reaches sample_rate-1, the block samples Serial_in, resets the counter to 0, and increments the bit counter.
  - Bit counter 0..word_size-1: the sample is shifted into the shift register, right-shift, MSB in. After word_size samples, the first-received bit is in bit 0.
  - Bit counter = word_size: the sample is the stop bit and triggers frame completion. On the next edge the block returns to IDLE.
- Frame completion, all updated on the same edge:
  - RCV_datareg ← shift register. The word is loaded even when a framing error occurs.
  - read_not_ready_out ← 1.
  - Error2 ← (stop sample == 0).
  - Error1 ← 1 if read_not_ready_out was 1 and read_done = 0 in that cycle, else 0. The new word overwrites the old word either way.
- Timing for sample_rate = 8, cycle 0 = first cycle Serial_in sampled 0:
  - start confirmed at edge of cycle 3;
  - data bit k sampled at cycle 11+8k;
  - stop bit sampled at cycle 75;
  - outputs change after the cycle-75 edge.
  - Earliest acceptance of the next start bit: cycle 77.
- Handshake:
  - read_done = 1 clears read_not_ready_out on the next edge. Error flags are unchanged by read_done.
  - read_done while read_not_ready_out = 0 has no effect.
  - read_done in the same cycle as frame completion: the acknowledge applies to the old word. read_not_ready_out stays 1, Error1 = 0.
- Error flags hold their values until the next frame completion or reset.
- Serial_in activity during RECEIVING is ignored except at sample points. There is no mid-frame resynchronization.

Test Plan:
- Reset: hold rst_b = 1 for 3 cycles with Serial_in = 0 → all outputs 0 and state IDLE. Deassert with Serial_in = 1 → outputs remain 0.
- Normal frame: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 8 cycles/bit → after cycle 75: RCV_datareg = 0xA5, read_not_ready_out = 1, Error1 = 0, Error2 = 0. Pulse read_done → read_not_ready_out = 0 next edge.
- Glitch rejection: Serial_in low for 2 cycles then high → stays IDLE, no output change. Then send 0x3C → RCV_datareg = 0x3C.
- Framing error: send 0x5A with stop bit 0 → RCV_datareg = 0x5A, read_not_ready_out = 1, Error2 = 1. Next good frame 0x01 → Error2 = 0.
- Overrun: send 0x11 with no read_done, then 0x22 → RCV_datareg = 0x22, Error1 = 1. Repeat with read_done asserted in the completion cycle of 0x22 → Error1 = 0, read_not_ready_out = 1.
- Reset mid-frame: assert rst_b for 1 cycle at cycle 40 of a frame → outputs 0, IDLE. Remaining bits are treated as line activity, and a subsequent full frame 0xFF is received correctly.
